// File: rtl/tx_word_funcmod_pkg.sv
// Shared constants, FSM encoding and hex helper for the SDRAM-demo word transmitter.
package tx_word_funcmod_pkg;

  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam int         BAUD_115K2_133M = 1157;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BIT   = 3'd2,
    ST_DONE  = 3'd3,
    ST_GUARD = 3'd4
  } t_state;

  // Uppercase ASCII for one nibble: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/tx_word_funcmod_byte.sv
// Single-byte UART shifter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
module tx_byte_funcmod
  import tx_word_funcmod_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_115K2_133M,
  parameter int STOP_BITS = 2
) (
  input  logic       CLOCK1,
  input  logic       RESET,
  input  logic       iCall,
  input  logic [7:0] iData,
  output logic       oDone,
  output logic       TXD
);

  localparam int FW = 9 + STOP_BITS;
  localparam int BW = $clog2(FW);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

  logic [FW-1:0] r_frame;
  logic [BW-1:0] r_bit;
  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          r_txd;

  logic [FW-1:0] w_frame;
  logic [BW-1:0] w_bit_nxt;
  logic          w_cnt_last;
  logic          w_bit_last;

  assign w_frame    = {{STOP_BITS{1'b1}}, iData, 1'b0};
  assign w_bit_nxt  = r_bit + 1'b1;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_bit_last = (r_bit == BIT_LAST);

  // TXD is registered, so the frame's first bit is loaded together with the frame.
  always_ff @(posedge CLOCK1 or negedge RESET) begin
    if (!RESET) begin
      r_frame  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_txd    <= 1'b1;
    end else if (iCall) begin
      r_frame  <= w_frame;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_txd    <= w_frame[0];
    end else if (r_active) begin
      if (w_cnt_last) begin
        r_cnt <= '0;
        if (w_bit_last) begin
          r_bit    <= '0;
          r_active <= 1'b0;
          r_txd    <= 1'b1;
        end else begin
          r_bit <= w_bit_nxt;
          r_txd <= r_frame[w_bit_nxt];
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Asserted during the final cycle of the last stop bit.
  assign oDone = r_active && w_cnt_last && w_bit_last;
  assign TXD   = r_txd;

endmodule

// File: rtl/tx_word_funcmod.sv
// Word transmitter: sequences 2 raw bytes or 6 hex/CRLF bytes through tx_byte_funcmod.
module tx_word_funcmod
  import tx_word_funcmod_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_115K2_133M,
  parameter int STOP_BITS = 2,
  parameter int HEX_MODE  = 0
) (
  input  logic        CLOCK1,
  input  logic        RESET,
  input  logic        iCall,
  input  logic [15:0] iData,
  output logic        oDone,
  output logic        oBusy,
  output logic        TXD
);

  localparam int         NBYTES   = (HEX_MODE != 0) ? 6 : 2;
  localparam logic [2:0] IDX_LAST = 3'(NBYTES - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2 || BAUD_DIV < 2) begin : g_bad_param
    $error("tx_word_funcmod: STOP_BITS must be 1..2 and BAUD_DIV >= 2");
  end

  t_state      r_state;
  logic [15:0] r_data;
  logic [2:0]  r_byte_idx;

  logic [7:0]  w_hex [0:3];
  logic [7:0]  w_byte;
  logic        w_byte_call;
  logic        w_byte_done;

  // w_hex[3] is the most significant nibble.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hex
    assign w_hex[gi] = hex_ascii(r_data[4*gi +: 4]);
  end

  always_comb begin
    w_byte = 8'h00;
    if (HEX_MODE != 0) begin
      case (r_byte_idx)
        3'd0:    w_byte = w_hex[3];
        3'd1:    w_byte = w_hex[2];
        3'd2:    w_byte = w_hex[1];
        3'd3:    w_byte = w_hex[0];
        3'd4:    w_byte = ASCII_CR;
        default: w_byte = ASCII_LF;
      endcase
    end else begin
      w_byte = (r_byte_idx == 3'd0) ? r_data[15:8] : r_data[7:0];
    end
  end

  assign w_byte_call = (r_state == ST_LOAD);

  always_ff @(posedge CLOCK1 or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iCall) begin
            r_data     <= iData;
            r_byte_idx <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD:  r_state <= ST_BIT;
        ST_BIT: begin
          if (w_byte_done) begin
            if (r_byte_idx == IDX_LAST) begin
              r_state <= ST_DONE;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end
        ST_DONE:  r_state <= ST_GUARD;
        ST_GUARD: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  tx_byte_funcmod #(
    .BAUD_DIV  (BAUD_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_byte (
    .CLOCK1 (CLOCK1),
    .RESET  (RESET),
    .iCall  (w_byte_call),
    .iData  (w_byte),
    .oDone  (w_byte_done),
    .TXD    (TXD)
  );

  assign oDone = (r_state == ST_DONE);
  assign oBusy = (r_state != ST_IDLE);

endmodule
